// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: FSM encoding and default widths.
// The MMIO address default is only consumed when MMIO_EN is defined.
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPTURE = 3'd2,
        WR_ISSUE   = 3'd3,
        RESP       = 3'd4
    } state_t;

    localparam int          DEF_ADDR_W    = 16;
    localparam int          DEF_DATA_W    = 16;
    localparam logic [15:0] DEF_MMIO_ADDR = 16'hFFFF;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for the asynchronous external input bus.
module io_sync2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding CPU-to-synchronous-RAM responder (read: 3 cycles, write: 2 cycles).
// Optional memory-mapped I/O register at MMIO_ADDR when MMIO_EN is defined.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef MMIO_EN
    ,
    parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(DEF_MMIO_ADDR)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef MMIO_EN
    ,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
`endif
);

    state_t            state, state_nxt;
    logic              mmio_hit;
    logic [DATA_W-1:0] rd_src;

`ifdef MMIO_EN
    logic [DATA_W-1:0] io_q;

    io_sync2 #(.W(DATA_W)) u_io_sync (
        .clk   (clk),
        .reset (reset),
        .d     (io_in),
        .q     (io_q)
    );

    // ram_addr holds the latched request address for the whole operation.
    assign mmio_hit = (ram_addr == MMIO_ADDR);
    assign rd_src   = mmio_hit ? io_q : ram_rdata;

    always_ff @(posedge clk) begin
        if (reset)
            io_out <= '0;
        else if (state == WR_ISSUE && mmio_hit)
            io_out <= ram_wdata;
    end
`else
    assign mmio_hit = 1'b0;
    assign rd_src   = ram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (req_valid) state_nxt = req_we ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = RESP;
            WR_ISSUE:   state_nxt = RESP;
            RESP:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
        ram_we     = (state == WR_ISSUE) && !mmio_hit;
    end

    // Request latch doubles as the registered RAM address/data drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                ram_addr  <= req_addr;
                ram_wdata <= req_wdata;
            end
            if (state == RD_CAPTURE)
                resp_rdata <= rd_src;
        end
    end

endmodule
